// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - RISC-V M-extension divide/remainder controller around a combinational divider core
//
// Sequences one DIV/DIVU/REM/REMU operation: captures operands on start, drives
// unsigned magnitudes to an external combinational divider core for WAIT_CYCLES
// cycles, then applies sign correction and the divide-by-zero / signed-overflow
// special cases and presents the result with a one-cycle done pulse.
//
// Optional feature macro: DIV_FASTPATH_EN
//   defined   - divide-by-zero and signed-overflow requests skip CALC and
//               complete in the cycle after start (no busy cycle)
//   undefined - every request takes the full CALC latency
//
// Ports:
//   Clock          in   rising-edge clock
//   nReset         in   asynchronous active-low reset
//   start          in   request strobe
//   op[1:0]        in   00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0])
//   rs1[31:0]      in   dividend
//   rs2[31:0]      in   divisor
//   busy           out  high while an operation is in CALC
//   done           out  one-cycle pulse, result valid
//   result[31:0]   out  final result, held until the next done
//   core_dividend  out  unsigned dividend magnitude to the core
//   core_divisor   out  unsigned divisor magnitude to the core
//   core_quotient  in   unsigned quotient from the core
//   core_remainder in   unsigned remainder from the core

module div_ctrl #(
    parameter int WAIT_CYCLES = 4
) (
    input  logic        Clock,
    input  logic        nReset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [31:0] core_dividend,
    output logic [31:0] core_divisor,
    input  logic [31:0] core_quotient,
    input  logic [31:0] core_remainder
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic [1:0]  op_r;
    logic        sign_a_r;
    logic        sign_b_r;
    logic        div_zero_r;
    logic        ovf_r;
    logic [31:0] mag_a_r;
    logic [31:0] mag_b_r;

    // Decode of the incoming request, used when start is accepted.
    logic        in_signed;
    logic        in_sign_a;
    logic        in_sign_b;
    logic        in_zero;
    logic        in_ovf;
    logic [31:0] in_mag_a;
    logic [31:0] in_mag_b;

    // Two's-complement negation when neg is set; 0x80000000 maps to itself,
    // which is the correct unsigned magnitude of INT_MIN.
    function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

    // Final M-extension result. Signs are only ever set for signed ops, so
    // the unsigned variants fall straight through the sign corrections.
    function automatic logic [31:0] final_result(
        input logic [1:0]  f_op,
        input logic        f_sign_a,
        input logic        f_sign_b,
        input logic        f_zero,
        input logic        f_ovf,
        input logic [31:0] f_mag_a,
        input logic [31:0] f_q,
        input logic [31:0] f_r
    );
        logic is_rem;
        is_rem = f_op[1];
        if (f_zero) begin
            // Rebuilding rs1 from its magnitude and sign gives rs1 unchanged.
            return is_rem ? cond_neg(f_mag_a, f_sign_a) : 32'hFFFF_FFFF;
        end else if (f_ovf) begin
            return is_rem ? 32'h0000_0000 : 32'h8000_0000;
        end else if (is_rem) begin
            return cond_neg(f_r, f_sign_a);
        end else begin
            return cond_neg(f_q, f_sign_a ^ f_sign_b);
        end
    endfunction

    always_comb begin
        in_signed = ~op[0];
        in_sign_a = in_signed & rs1[31];
        in_sign_b = in_signed & rs2[31];
        in_zero   = (rs2 == 32'd0);
        in_ovf    = in_signed & (rs1 == 32'h8000_0000) & (rs2 == 32'hFFFF_FFFF);
        in_mag_a  = cond_neg(rs1, in_sign_a);
        in_mag_b  = cond_neg(rs2, in_sign_b);
    end

    // The core only ever sees registered magnitudes, so its inputs stay
    // constant for the whole CALC window.
    assign core_dividend = mag_a_r;
    assign core_divisor  = mag_b_r;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            op_r       <= 2'd0;
            sign_a_r   <= 1'b0;
            sign_b_r   <= 1'b0;
            div_zero_r <= 1'b0;
            ovf_r      <= 1'b0;
            mag_a_r    <= 32'd0;
            mag_b_r    <= 32'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= 32'd0;
        end else begin
            case (state)
                IDLE, FINISH: begin
                    if (start) begin
                        op_r       <= op;
                        sign_a_r   <= in_sign_a;
                        sign_b_r   <= in_sign_b;
                        div_zero_r <= in_zero;
                        ovf_r      <= in_ovf;
                        mag_a_r    <= in_mag_a;
                        mag_b_r    <= in_mag_b;
`ifdef DIV_FASTPATH_EN
                        if (in_zero || in_ovf) begin
                            // Result does not depend on the core: finish now.
                            state  <= FINISH;
                            cnt    <= 4'd0;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            result <= final_result(op, in_sign_a, in_sign_b, in_zero,
                                                   in_ovf, in_mag_a, 32'd0, 32'd0);
                        end else begin
                            state <= CALC;
                            cnt   <= CNT_LOAD;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end
`else
                        state <= CALC;
                        cnt   <= CNT_LOAD;
                        busy  <= 1'b1;
                        done  <= 1'b0;
`endif
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                end

                CALC: begin
                    // start is deliberately ignored here.
                    if (cnt == 4'd0) begin
                        state  <= FINISH;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        result <= final_result(op_r, sign_a_r, sign_b_r, div_zero_r,
                                               ovf_r, mag_a_r, core_quotient,
                                               core_remainder);
                    end else begin
                        cnt  <= cnt - 4'd1;
                        busy <= 1'b1;
                        done <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= 4'd0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// tb/tb_div_ctrl.sv - directed self-checking bench for div_ctrl

module tb_div_ctrl;

    logic        Clock;
    logic        nReset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [31:0] core_dividend;
    logic [31:0] core_divisor;
    logic [31:0] core_quotient;
    logic [31:0] core_remainder;

    int total = 0;
    int bad   = 0;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    div_ctrl #(.WAIT_CYCLES(4)) dut (
        .Clock          (Clock),
        .nReset         (nReset),
        .start          (start),
        .op             (op),
        .rs1            (rs1),
        .rs2            (rs2),
        .busy           (busy),
        .done           (done),
        .result         (result),
        .core_dividend  (core_dividend),
        .core_divisor   (core_divisor),
        .core_quotient  (core_quotient),
        .core_remainder (core_remainder)
    );

    // Behavioural unsigned divider core; its zero-divisor output is irrelevant.
    assign core_quotient  = (core_divisor == 32'd0) ? 32'hFFFF_FFFF : core_dividend / core_divisor;
    assign core_remainder = (core_divisor == 32'd0) ? core_dividend : core_dividend % core_divisor;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues one request (start sampled at edge 0) and follows it to done.
    // ma/mb are the expected core magnitudes, checked in cycle 1 of CALC.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp,
                          input logic [31:0] ma, input logic [31:0] mb);
        int lat;
        logic special;
        special = (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        lat = 5;
`ifdef DIV_FASTPATH_EN
        if (special) lat = 1;
`endif
        @(negedge Clock);
        start = 1'b1; op = o; rs1 = a; rs2 = b;
        @(posedge Clock); #1;
        start = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            if (k > 1) begin
                @(posedge Clock); #1;
            end
            if (k < lat) begin
                check({tag, " busy"}, 32'(busy), 32'd1);
                check({tag, " no_done"}, 32'(done), 32'd0);
                if (k == 1) begin
                    check({tag, " core_dividend"}, core_dividend, ma);
                    check({tag, " core_divisor"}, core_divisor, mb);
                end
            end else begin
                check({tag, " done"}, 32'(done), 32'd1);
                check({tag, " busy_low"}, 32'(busy), 32'd0);
                check({tag, " result"}, result, exp);
            end
        end
        @(posedge Clock); #1;
        check({tag, " done_pulse"}, 32'(done), 32'd0);
        check({tag, " result_hold"}, result, exp);
    endtask

    initial begin
        nReset = 1'b0;
        start  = 1'b0;
        op     = 2'b00;
        rs1    = 32'd0;
        rs2    = 32'd0;
        #12;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", result, 32'd0);
        check("reset core_dividend", core_dividend, 32'd0);
        check("reset core_divisor", core_divisor, 32'd0);
        @(negedge Clock);
        nReset = 1'b1;

        run_op("div_m7_2",   OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'd7, 32'd2);
        run_op("rem_m7_2",   OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'd7, 32'd2);
        run_op("remu_m7_2",  OP_REMU, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 32'hFFFF_FFF9, 32'd2);
        run_op("divu_m7_2",  OP_DIVU, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'hFFFF_FFF9, 32'd2);
        run_op("div_7_m2",   OP_DIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd7, 32'd2);
        run_op("rem_7_m2",   OP_REM,  32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'd7, 32'd2);
        run_op("div_min_2",  OP_DIV,  32'h8000_0000, 32'd2, 32'hC000_0000, 32'h8000_0000, 32'd2);
        run_op("divu_zero",  OP_DIVU, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234, 32'd0);
        run_op("remu_zero",  OP_REMU, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'h0000_1234, 32'd0);
        run_op("rem_neg_zero", OP_REM, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'd7, 32'd0);
        run_op("div_ovf",    OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'd1);
        run_op("rem_ovf",    OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 32'd1);

        // Reset in cycle 2 of CALC abandons the operation.
        @(negedge Clock);
        start = 1'b1; op = OP_DIVU; rs1 = 32'd1000; rs2 = 32'd3;
        @(posedge Clock); #1;
        start = 1'b0;
        @(posedge Clock); #1;
        check("rst_mid busy_before", 32'(busy), 32'd1);
        nReset = 1'b0;
        #1;
        check("rst_mid busy", 32'(busy), 32'd0);
        check("rst_mid done", 32'(done), 32'd0);
        check("rst_mid result", result, 32'd0);
        check("rst_mid core_dividend", core_dividend, 32'd0);
        for (int k = 0; k < 6; k++) begin
            @(posedge Clock); #1;
            check("rst_mid no_done", 32'(done), 32'd0);
        end
        @(negedge Clock);
        nReset = 1'b1;
        run_op("divu_after_rst", OP_DIVU, 32'd100, 32'd7, 32'd14, 32'd100, 32'd7);

        // start held through CALC and FINISH: CALC ignores it, FINISH relaunches.
        @(negedge Clock);
        start = 1'b1; op = OP_DIVU; rs1 = 32'd100; rs2 = 32'd7;
        @(posedge Clock); #1;
        op = OP_REMU;
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) begin
                @(posedge Clock); #1;
            end
            check("b2b first busy", 32'(busy), 32'd1);
            check("b2b first no_done", 32'(done), 32'd0);
        end
        @(posedge Clock); #1;
        check("b2b first done", 32'(done), 32'd1);
        check("b2b first result", result, 32'd14);
        @(posedge Clock); #1;
        start = 1'b0;
        for (int k = 6; k <= 9; k++) begin
            if (k > 6) begin
                @(posedge Clock); #1;
            end
            check("b2b second busy", 32'(busy), 32'd1);
            check("b2b second no_done", 32'(done), 32'd0);
        end
        @(posedge Clock); #1;
        check("b2b second done", 32'(done), 32'd1);
        check("b2b second result", result, 32'd2);
        @(posedge Clock); #1;
        check("b2b idle done", 32'(done), 32'd0);
        check("b2b idle busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
